// File: rtl/npc_lut_pkg.sv
// Shared types and helpers for the key lookup CAM.
// Entry fields are sized to the widest supported key/data (64 bits);
// instances zero-extend narrower keys and data into them.
package npc_lut_pkg;

  localparam int unsigned ENTRY_KEY_W  = 64;
  localparam int unsigned ENTRY_DATA_W = 64;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_KEY_W-1:0]  key;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;

  // Width needed to hold a count from 0 up to nr_entry inclusive.
  function automatic int unsigned cnt_width(input int unsigned nr_entry);
    return $clog2(nr_entry + 1);
  endfunction

endpackage

// File: rtl/key_lut_cam_if.sv
// Write, lookup and response channels of the key lookup CAM.
// master drives requests and rsp_ready; slave is the CAM side.
interface key_lut_cam_if #(
  parameter int unsigned KEY_LEN  = 8,
  parameter int unsigned DATA_LEN = 32
);

  logic                wr_valid;
  logic                wr_ready;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                flush;
  logic                lk_valid;
  logic                lk_ready;
  logic [KEY_LEN-1:0]  lk_key;
  logic [DATA_LEN-1:0] default_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_hit;
  logic [DATA_LEN-1:0] rsp_data;

  modport master (
    output wr_valid, wr_key, wr_data, flush, lk_valid, lk_key, default_out, rsp_ready,
    input  wr_ready, lk_ready, rsp_valid, rsp_hit, rsp_data
  );

  modport slave (
    input  wr_valid, wr_key, wr_data, flush, lk_valid, lk_key, default_out, rsp_ready,
    output wr_ready, lk_ready, rsp_valid, rsp_hit, rsp_data
  );

endinterface

// File: rtl/lut_match.sv
// Combinational key compare against all table entries.
// Produces a one-hot hit vector (keys are unique among valid entries)
// and a summary hit flag.
module lut_match #(
  parameter int unsigned NR_ENTRY = 8,
  parameter int unsigned KEY_W    = 8
) (
  input  logic [KEY_W-1:0]               key,
  input  logic [NR_ENTRY-1:0][KEY_W-1:0] keys,
  input  logic [NR_ENTRY-1:0]            valids,
  output logic [NR_ENTRY-1:0]            hit_vec,
  output logic                           hit
);

  // Per-entry match: only valid entries may hit.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < NR_ENTRY; i++) begin
      hit_vec[i] = valids[i] && (keys[i] == key);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/key_lut_cam.sv
// Key lookup CAM: small fully-associative key->data table with an
// insert-or-update write channel, flush, and a 1-cycle registered lookup.
// On a full table a missing write replaces the round-robin victim.
// Optional build macro: KEY_LUT_CAM_STATS_EN adds hit_cnt / miss_cnt.
module key_lut_cam
  import npc_lut_pkg::*;
#(
  parameter int unsigned NR_ENTRY    = 8,
  parameter int unsigned KEY_LEN     = 8,
  parameter int unsigned DATA_LEN    = 32,
  parameter bit          HAS_DEFAULT = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  key_lut_cam_if.slave                       bus,
  output logic [cnt_width(NR_ENTRY)-1:0]     count,
  output logic                               full
`ifdef KEY_LUT_CAM_STATS_EN
  ,
  output logic [31:0]                        hit_cnt,
  output logic [31:0]                        miss_cnt
`endif
);

  localparam int unsigned CNT_W = cnt_width(NR_ENTRY);
  localparam int unsigned PTR_W = $clog2(NR_ENTRY);

  entry_t                              tbl [NR_ENTRY];
  logic [NR_ENTRY-1:0]                 valids;
  logic [NR_ENTRY-1:0][ENTRY_KEY_W-1:0] keys;

  logic [ENTRY_KEY_W-1:0] lk_key_ext;
  logic [ENTRY_KEY_W-1:0] wr_key_ext;
  logic [NR_ENTRY-1:0]    lk_hit_vec;
  logic [NR_ENTRY-1:0]    wr_hit_vec;
  logic                   lk_hit;
  logic                   wr_hit;
  logic [DATA_LEN-1:0]    lk_data;

  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       free_idx;
  logic [PTR_W-1:0]       wr_idx;
  logic                   free_found;

  logic                   wr_fire;
  logic                   lk_fire;

  logic                   rsp_valid_q;
  logic                   rsp_hit_q;
  logic [DATA_LEN-1:0]    rsp_data_q;

  // Handshake readiness: writes blocked by flush; lookups stall only
  // when a response is pending and not being taken.
  assign bus.wr_ready = !bus.flush;
  assign bus.lk_ready = !rsp_valid_q || bus.rsp_ready;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign lk_fire      = bus.lk_valid && bus.lk_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_data  = rsp_data_q;

  assign full       = (count == CNT_W'(NR_ENTRY));
  assign lk_key_ext = ENTRY_KEY_W'(bus.lk_key);
  assign wr_key_ext = ENTRY_KEY_W'(bus.wr_key);

  // Flatten table keys/valids for the compare units.
  always_comb begin
    valids = '0;
    keys   = '0;
    for (int unsigned i = 0; i < NR_ENTRY; i++) begin
      valids[i] = tbl[i].valid;
      keys[i]   = tbl[i].key;
    end
  end

  lut_match #(
    .NR_ENTRY (NR_ENTRY),
    .KEY_W    (ENTRY_KEY_W)
  ) u_lk_match (
    .key     (lk_key_ext),
    .keys    (keys),
    .valids  (valids),
    .hit_vec (lk_hit_vec),
    .hit     (lk_hit)
  );

  lut_match #(
    .NR_ENTRY (NR_ENTRY),
    .KEY_W    (ENTRY_KEY_W)
  ) u_wr_match (
    .key     (wr_key_ext),
    .keys    (keys),
    .valids  (valids),
    .hit_vec (wr_hit_vec),
    .hit     (wr_hit)
  );

  // One-hot data select for the lookup result.
  always_comb begin
    lk_data = '0;
    for (int unsigned i = 0; i < NR_ENTRY; i++) begin
      if (lk_hit_vec[i]) begin
        lk_data = lk_data | tbl[i].data[DATA_LEN-1:0];
      end
    end
  end

  // Insert slot: lowest invalid entry, or the round-robin victim when full.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NR_ENTRY; i++) begin
      if (!valids[i] && !free_found) begin
        free_idx   = PTR_W'(i);
        free_found = 1'b1;
      end
    end
    wr_idx = full ? rr_ptr : free_idx;
  end

  // Table storage: flush clears valids and wins over a same-cycle write;
  // lookups read the table before this edge updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR_ENTRY; i++) begin
        tbl[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int unsigned i = 0; i < NR_ENTRY; i++) begin
        tbl[i].valid <= 1'b0;
      end
    end else if (wr_fire) begin
      if (wr_hit) begin
        for (int unsigned i = 0; i < NR_ENTRY; i++) begin
          if (wr_hit_vec[i]) begin
            tbl[i].data <= ENTRY_DATA_W'(bus.wr_data);
          end
        end
      end else begin
        tbl[wr_idx].valid <= 1'b1;
        tbl[wr_idx].key   <= wr_key_ext;
        tbl[wr_idx].data  <= ENTRY_DATA_W'(bus.wr_data);
      end
    end
  end

  // Occupancy count and victim pointer; the pointer only moves on a replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rr_ptr <= '0;
    end else if (bus.flush) begin
      count  <= '0;
      rr_ptr <= '0;
    end else if (wr_fire && !wr_hit) begin
      if (full) begin
        rr_ptr <= (rr_ptr == PTR_W'(NR_ENTRY - 1)) ? '0 : rr_ptr + 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Registered response; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (lk_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= lk_hit;
      if (lk_hit) begin
        rsp_data_q <= lk_data;
      end else begin
        rsp_data_q <= HAS_DEFAULT ? bus.default_out : '0;
      end
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef KEY_LUT_CAM_STATS_EN
  // Accepted-lookup statistics, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lk_fire) begin
      if (lk_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_lut_cam.sv
// Directed bench for key_lut_cam with a response scoreboard.
// A second instance with HAS_DEFAULT=0 checks the zero-on-miss variant.
module tb_key_lut_cam;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] count, count0;
  logic       full, full0;
`ifdef KEY_LUT_CAM_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, hit_cnt0, miss_cnt0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  key_lut_cam_if #(.KEY_LEN(8), .DATA_LEN(32)) bus  ();
  key_lut_cam_if #(.KEY_LEN(8), .DATA_LEN(32)) bus0 ();

  key_lut_cam #(
    .NR_ENTRY(8), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .count(count), .full(full)
`ifdef KEY_LUT_CAM_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  key_lut_cam #(
    .NR_ENTRY(8), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .count(count0), .full(full0)
`ifdef KEY_LUT_CAM_STATS_EN
    , .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every delivered response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      n_tests++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected: observed queue size %0d required >0", q.size());
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_hit", 64'(bus.rsp_hit), 64'(e.hit));
        chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rel_lk_ready", 64'(bus.lk_ready), 64'd1);
    chk("rel_wr_ready", 64'(bus.wr_ready), 64'd1);
  endtask

  task automatic wr(input logic [7:0] k, input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_key   = k;
    bus.wr_data  = d;
    cyc();
    bus.wr_valid = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] k, input logic h, input logic [31:0] d);
    exp_t e;
    for (int i = 0; i < 20 && !bus.lk_ready; i++) cyc();
    chk("lk_ready_wait", 64'(bus.lk_ready), 64'd1);
    bus.lk_valid = 1'b1;
    bus.lk_key   = k;
    e.hit  = h;
    e.data = d;
    q.push_back(e);
    cyc();
    bus.lk_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid = 0; bus.wr_key = 0; bus.wr_data = 0; bus.flush = 0;
    bus.lk_valid = 0; bus.lk_key = 0; bus.default_out = 32'hA5A5A5A5; bus.rsp_ready = 1;
    bus0.wr_valid = 0; bus0.wr_key = 0; bus0.wr_data = 0; bus0.flush = 0;
    bus0.lk_valid = 0; bus0.lk_key = 0; bus0.default_out = 0; bus0.rsp_ready = 1;
    #2;
    do_reset();

    // Same-cycle write and lookup: lookup sees the empty table.
    bus.wr_valid = 1'b1; bus.wr_key = 8'h12; bus.wr_data = 32'h1;
    lookup(8'h12, 1'b0, 32'hA5A5A5A5);
    bus.wr_valid = 1'b0;
    lookup(8'h12, 1'b1, 32'h1);
    chk("count_after_insert", 64'(count), 64'd1);

    // Update in place keeps count.
    wr(8'h12, 32'hDEADBEEF);
    chk("count_after_update", 64'(count), 64'd1);
    lookup(8'h12, 1'b1, 32'hDEADBEEF);

    // Miss with default, and the zero-default variant.
    bus.default_out = 32'hFFFF0000;
    lookup(8'h55, 1'b0, 32'hFFFF0000);
    bus0.default_out = 32'hFFFF0000;
    bus0.lk_valid = 1'b1; bus0.lk_key = 8'h55;
    cyc();
    bus0.lk_valid = 1'b0;
    chk("nodef_rsp_valid", 64'(bus0.rsp_valid), 64'd1);
    chk("nodef_rsp_hit", 64'(bus0.rsp_hit), 64'd0);
    chk("nodef_rsp_data", 64'(bus0.rsp_data), 64'd0);
    cyc();

    // Backpressure: response held 3 cycles, a queued lookup waits.
    bus.rsp_ready = 1'b0;
    lookup(8'h12, 1'b1, 32'hDEADBEEF);
    bus.default_out = 32'h22222222;
    bus.lk_valid = 1'b1; bus.lk_key = 8'h55;
    for (int i = 0; i < 3; i++) begin
      chk("hold_lk_ready", 64'(bus.lk_ready), 64'd0);
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rsp_hit", 64'(bus.rsp_hit), 64'd1);
      chk("hold_rsp_data", 64'(bus.rsp_data), 64'hDEADBEEF);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    begin
      exp_t e;
      e.hit = 1'b0; e.data = 32'h22222222;
      q.push_back(e);
    end
    cyc();
    bus.lk_valid = 1'b0;
    cyc();
    cyc();
    chk("hold_drain", 64'(q.size()), 64'd0);

    // Default is captured at acceptance, not at delivery.
    bus.rsp_ready = 1'b0;
    bus.default_out = 32'h11111111;
    lookup(8'h77, 1'b0, 32'h11111111);
    bus.default_out = 32'h33333333;
    cyc();
    cyc();
    chk("default_sampled", 64'(bus.rsp_data), 64'h11111111);
    bus.rsp_ready = 1'b1;
    cyc();
    cyc();

    // Reset with a pending response discards it at once.
    bus.rsp_ready = 1'b0;
    lookup(8'h12, 1'b1, 32'hDEADBEEF);
    chk("pend_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    do_reset();

    // Fill and replacement.
    bus.default_out = 32'hA5A5A5A5;
    for (int k = 0; k < 9; k++) begin
      wr(8'(k), 32'h100 + 32'(k));
      if (k == 6) begin
        chk("fill_full_k6", 64'(full), 64'd0);
        chk("fill_count_k6", 64'(count), 64'd7);
      end
      if (k == 7) begin
        chk("fill_full_k7", 64'(full), 64'd1);
        chk("fill_count_k7", 64'(count), 64'd8);
      end
      if (k == 8) begin
        chk("fill_count_k8", 64'(count), 64'd8);
        chk("fill_full_k8", 64'(full), 64'd1);
      end
    end
    lookup(8'd0, 1'b0, 32'hA5A5A5A5);
    lookup(8'd8, 1'b1, 32'h108);
    lookup(8'd1, 1'b1, 32'h101);
    // Victim pointer now at entry 1: key 9 evicts key 1.
    wr(8'd9, 32'h109);
    lookup(8'd1, 1'b0, 32'hA5A5A5A5);
    lookup(8'd9, 1'b1, 32'h109);
    lookup(8'd2, 1'b1, 32'h102);
    cyc();

    // Flush beats a same-cycle write; same-cycle lookup sees old table.
    do_reset();
    for (int k = 0; k < 4; k++) wr(8'h20 + 8'(k), 32'h200 + 32'(k));
    chk("pre_flush_count", 64'(count), 64'd4);
    bus.flush = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_key = 8'h30; bus.wr_data = 32'h5;
    #1;
    chk("flush_wr_ready", 64'(bus.wr_ready), 64'd0);
    lookup(8'h21, 1'b1, 32'h201);
    bus.flush = 1'b0;
    bus.wr_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_full", 64'(full), 64'd0);
    lookup(8'h30, 1'b0, 32'hA5A5A5A5);
    lookup(8'h21, 1'b0, 32'hA5A5A5A5);
    wr(8'h40, 32'hABCD);
    chk("post_flush_count", 64'(count), 64'd1);
    lookup(8'h40, 1'b1, 32'hABCD);
    cyc();
    cyc();
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
